// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiplier.
package mul_pkg;

  // FSM encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;

  // Sign modes: bit 1 marks A signed, bit 0 marks B signed
  localparam logic [1:0] SN_UU = 2'b00;
  localparam logic [1:0] SN_US = 2'b01;
  localparam logic [1:0] SN_SU = 2'b10;
  localparam logic [1:0] SN_SS = 2'b11;

  // RV32M multiply funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // Map an RV32M funct3 to the sign mode fed to the multiplier.
  // MUL only uses the low half, where signedness does not matter.
  function automatic logic [1:0] sn_from_funct3(input logic [2:0] f3);
    logic [1:0] s;
    s = SN_SS;
    case (f3)
      F3_MUL:    s = SN_SS;
      F3_MULH:   s = SN_SS;
      F3_MULHSU: s = SN_SU;
      F3_MULHU:  s = SN_UU;
      default:   s = SN_SS;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mul_iter_step.sv
// One radix-2^K step: multiply |A| by K multiplier bits and add the
// partial product, shifted to its digit position, into the accumulator.
module mul_iter_step
  import mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int K    = 2,
  parameter int IW   = 5
) (
  input  logic [XLEN-1:0]   a_mag,
  input  logic [K-1:0]      b_bits,
  input  logic [IW-1:0]     idx,
  input  logic [2*XLEN-1:0] acc_in,
  output logic [2*XLEN-1:0] acc_out
);

  localparam int PW = XLEN + K;
  localparam int SW = IW + 3;

  logic [PW-1:0] pp_terms [K];
  logic [PW-1:0] pp;
  logic [SW-1:0] shamt;

  // One shifted copy of |A| per multiplier bit
  for (genvar gi = 0; gi < K; gi++) begin : g_pp
    assign pp_terms[gi] = b_bits[gi] ? (PW'(a_mag) << gi) : '0;
  end

  // Sum the K partial terms into the step's partial product
  always_comb begin
    pp = '0;
    for (int i = 0; i < K; i++) begin
      pp = pp + pp_terms[i];
    end
  end

  assign shamt   = SW'(idx) * SW'(K);
  assign acc_out = acc_in + ((2*XLEN)'(pp) << shamt);

endmodule

// File: rtl/mul_iter.sv
// Iterative sign-magnitude multiplier retiring K multiplier bits per cycle.
// Operands are converted to magnitudes at accept, multiplied unsigned, and
// the product is negated on the final CALC write when the signs differ.
module mul_iter
  import mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int K    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [1:0]        sn,
  input  logic              kill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*XLEN-1:0] product,
  output logic              busy
);

  localparam int STEPS = XLEN / K;
  localparam int IW    = $clog2(STEPS + 1);

  state_t            state_reg;
  logic [XLEN-1:0]   a_mag_reg;
  logic [XLEN-1:0]   b_mag_reg;
  logic              neg_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [IW-1:0]     cnt_reg;

  logic              accept;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag_next;
  logic [XLEN-1:0]   b_mag_next;
  logic [IW-1:0]     step_idx;
  logic [2*XLEN-1:0] step_sum;
  logic [2*XLEN-1:0] final_next;

  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign product   = acc_reg;

  // kill holds off acceptance even while in_ready is asserted
  assign accept = in_valid && in_ready && !kill;

  // Operand magnitudes; -2^(XLEN-1) maps to 2^(XLEN-1), which still fits unsigned
  assign a_neg      = sn[1] & op_a[XLEN-1];
  assign b_neg      = sn[0] & op_b[XLEN-1];
  assign a_mag_next = a_neg ? (~op_a + 1'b1) : op_a;
  assign b_mag_next = b_neg ? (~op_b + 1'b1) : op_b;

  // Digit position counts up from zero as the counter counts down
  assign step_idx = IW'(STEPS) - cnt_reg;

  mul_iter_step #(
    .XLEN (XLEN),
    .K    (K),
    .IW   (IW)
  ) u_step (
    .a_mag   (a_mag_reg),
    .b_bits  (b_mag_reg[K-1:0]),
    .idx     (step_idx),
    .acc_in  (acc_reg),
    .acc_out (step_sum)
  );

  // Full-width two's complement on the last step; negating zero stays zero
  assign final_next = neg_reg ? (~step_sum + 1'b1) : step_sum;

  // FSM and datapath registers; kill outranks both consume and accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_mag_reg <= '0;
      b_mag_reg <= '0;
      neg_reg   <= 1'b0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else if (kill && (state_reg != IDLE)) begin
      state_reg <= IDLE;
    end else if (accept) begin
      a_mag_reg <= a_mag_next;
      b_mag_reg <= b_mag_next;
      neg_reg   <= a_neg ^ b_neg;
      acc_reg   <= '0;
      cnt_reg   <= IW'(STEPS);
      state_reg <= CALC;
    end else begin
      case (state_reg)
        CALC: begin
          b_mag_reg <= b_mag_reg >> K;
          cnt_reg   <= cnt_reg - 1'b1;
          if (cnt_reg == IW'(1)) begin
            acc_reg   <= final_next;
            state_reg <= DONE;
          end else begin
            acc_reg <= step_sum;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: the driver pushes reference products at
// accept, a negedge monitor pops and compares whenever a product is shown.
module tb_mul_iter;

  localparam int XLEN = 32;
  localparam int K    = 2;
  localparam int LAT  = XLEN / K;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [1:0]        sn;
  logic              kill;
  logic              out_valid;
  logic              out_ready;
  logic [2*XLEN-1:0] product;
  logic              busy;

  typedef struct {
    logic [63:0] p;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  bit   rand_ready = 1'b0;

  mul_iter #(.XLEN(XLEN), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sn        (sn),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: sign- or zero-extend both operands and multiply as integers
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] s);
    logic signed [64:0]  ea;
    logic signed [64:0]  eb;
    logic signed [129:0] p;
    ea = s[1] ? {{33{a[31]}}, a} : {33'b0, a};
    eb = s[0] ? {{33{b[31]}}, b} : {33'b0, b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one operation and wait (bounded) for it to be accepted
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
    int n;
    bit done;
    n = 0;
    done = 0;
    op_a = a;
    op_b = b;
    sn = s;
    in_valid = 1'b1;
    while (!done && n < 300) begin
      @(negedge clk);
      if (in_ready && !kill) begin
        sb.push_back('{p: model(a, b, s), acc_cyc: cyc + 1});
        done = 1;
      end
      n++;
    end
    if (!done) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    sn = 2'($urandom_range(0, 3));
    $display("op a=%h b=%h sn=%b expect=%h", a, b, s, model(a, b, s));
  endtask

  // Wait (bounded) until every expected product has been consumed
  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare every presented product against the scoreboard head
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      prev_valid <= out_valid;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!prev_valid) chk("latency", 64'(cyc), 64'(sb[0].acc_cyc + LAT));
          chk("product", product, sb[0].p);
          chk("in_ready_done", 64'(in_ready), 64'(out_ready));
          if (out_ready && !kill) void'(sb.pop_front());
        end
      end
    end
  end

  // Random consumer backpressure during the sweep
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [31:0] corner [6];
    logic [31:0] ra;
    logic [31:0] rb;
    int n;
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;
    corner[5] = 32'h8000_0001;

    rst = 1'b1;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    sn = 2'b00;
    kill = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed sign-mode corners
    issue(32'hFFFF_FFFF, 32'h0000_0003, 2'b11);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    issue(32'h8000_0000, 32'h8000_0000, 2'b11);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b10);
    issue(32'h0000_0000, 32'h8000_0000, 2'b01);
    wait_drain();
    chk("fixed_ss", model(32'hFFFF_FFFF, 32'h3, 2'b11), 64'hFFFF_FFFF_FFFF_FFFD);

    // Backpressure in DONE, then consume and accept on the same edge
    out_ready = 1'b0;
    issue(32'd7, 32'd9, 2'b00);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_reach_done", 64'(out_valid), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_product", product, 64'd63);
    op_a = 32'd2;
    op_b = 32'd3;
    sn = 2'b00;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_ready", 64'(in_ready), 64'd1);
    if (in_ready) sb.push_back('{p: 64'd6, acc_cyc: cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accept_busy", 64'(busy), 64'd1);
    chk("bp_valid_drop", 64'(out_valid), 64'd0);
    wait_drain();
    $display("backpressure: product 6 expected after same-edge accept");

    // kill on the 7th CALC cycle discards the result
    issue(32'd11, 32'd13, 2'b00);
    repeat (6) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_busy", 64'(busy), 64'd0);
    chk("kill_out_valid", 64'(out_valid), 64'd0);
    void'(sb.pop_back());
    repeat (25) @(posedge clk);
    #1;
    issue(32'd5, 32'd7, 2'b00);
    wait_drain();
    $display("kill: discarded 11*13, then 5*7 expected 35");

    // kill in IDLE blocks acceptance
    op_a = 32'd3;
    op_b = 32'd3;
    in_valid = 1'b1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    kill = 1'b0;
    chk("kill_idle_block", 64'(busy), 64'd0);

    // Asynchronous reset mid-CALC
    issue(32'h1234_5678, 32'h9ABC_DEF0, 2'b11);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_product", product, 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("async reset mid-CALC checked");

    // Random sweep across all sign modes with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      issue(ra, rb, 2'($urandom_range(0, 3)));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
